// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10 (or a cache hit),
// then one inverse round per clock while the key schedule is unwound in step.
module aes_dec #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         data_valid_in,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         ready_out,
  output logic [127:0] res_dec_out,
  output logic         res_valid_out
);

  typedef enum logic [2:0] {IDLE, EXPAND, WHITEN, ROUND, FINAL, DONE} state_t;

  state_t       r_state;
  logic [127:0] r_data;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [127:0] r_cipherKey;
  logic [127:0] r_cacheKey;
  logic [127:0] r_cacheRk10;
  logic         r_cacheValid;
  logic         r_ready;
  logic         r_resValid;
  logic [127:0] r_result;

  logic [127:0] w_fwdKey;
  logic [127:0] w_invKey;
  logic [127:0] w_subbed;
  logic [127:0] w_addKey;
  logic [127:0] w_mixed;
  logic [31:0]  w_invW1, w_invW2, w_invW3;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic         w_hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign w_hit = (KEY_CACHE != 0) && r_cacheValid && (key_in == r_cacheKey);

  aes_key_scheduling u_fwdKey (
    .i_key  (r_key),
    .i_rcon (r_rcon),
    .o_key  (w_fwdKey)
  );

  // Inverse key step: recover rk(r-1) from rk(r) using the rcon that produced rk(r).
  assign w_invW3   = r_key[31:0]  ^ r_key[63:32];
  assign w_invW2   = r_key[63:32] ^ r_key[95:64];
  assign w_invW1   = r_key[95:64] ^ r_key[127:96];
  assign w_rotWord = {w_invW3[23:0], w_invW3[31:24]};
  assign w_invKey  = {r_key[127:96] ^ w_subWord ^ {r_rcon, 24'h000000}, w_invW1, w_invW2, w_invW3};

  for (genvar b = 0; b < 4; b++) begin : g_keySbox
    aes_sbox u_sbox (
      .i_in  (w_rotWord[31-8*b -: 8]),
      .o_out (w_subWord[31-8*b -: 8])
    );
  end

  // InvShiftRows is pure wiring into the inverse S-boxes: row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC_IDX = 4 * ((c + 4 - r) % 4) + r;
      localparam int DST_IDX = 4 * c + r;
      aes_inv_sbox u_invSbox (
        .i_in  (r_data[127-8*SRC_IDX -: 8]),
        .o_out (w_subbed[127-8*DST_IDX -: 8])
      );
    end
    assign w_mixed[127-32*c -: 32] = invMixCol(w_addKey[127-32*c -: 32]);
  end

  assign w_addKey = w_subbed ^ r_key;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_resValid   <= 1'b0;
      r_result     <= '0;
      r_cacheValid <= 1'b0;
      r_data       <= '0;
      r_key        <= '0;
      r_rcon       <= 8'h01;
      r_round      <= '0;
      r_cipherKey  <= '0;
      r_cacheKey   <= '0;
      r_cacheRk10  <= '0;
    end else begin
      r_resValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_valid_in) begin
            r_data      <= data_in;
            r_cipherKey <= key_in;
            r_round     <= '0;
            r_ready     <= 1'b0;
            if (w_hit) begin
              r_key   <= r_cacheRk10;
              r_rcon  <= 8'h36;
              r_state <= WHITEN;
            end else begin
              r_key   <= key_in;
              r_rcon  <= 8'h01;
              r_state <= EXPAND;
            end
          end
        end
        EXPAND: begin
          r_key   <= w_fwdKey;
          r_rcon  <= xtime(r_rcon);
          r_round <= r_round + 4'd1;
          if (r_round == 4'd9) begin
            r_rcon  <= 8'h36;
            r_round <= '0;
            r_state <= WHITEN;
            if (KEY_CACHE != 0) begin
              r_cacheKey   <= r_cipherKey;
              r_cacheRk10  <= w_fwdKey;
              r_cacheValid <= 1'b1;
            end
          end
        end
        WHITEN: begin
          r_data  <= r_data ^ r_key;
          r_key   <= w_invKey;
          r_rcon  <= (r_rcon == 8'h1b) ? 8'h80 : {1'b0, r_rcon[7:1]};
          r_state <= ROUND;
        end
        ROUND: begin
          r_data  <= w_mixed;
          r_key   <= w_invKey;
          r_rcon  <= (r_rcon == 8'h1b) ? 8'h80 : {1'b0, r_rcon[7:1]};
          r_round <= r_round + 4'd1;
          if (r_round == 4'd8) begin
            r_round <= '0;
            r_state <= FINAL;
          end
        end
        FINAL: begin
          r_data     <= w_addKey;
          r_result   <= w_addKey;
          r_resValid <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_out     = r_ready;
  assign res_valid_out = r_resValid;
  assign res_dec_out   = r_result;

endmodule

// Forward AES-128 key step rk(r-1) -> rk(r), shared with the encryption core.
module aes_key_scheduling (
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_w0, w_w1, w_w2, w_w3;

  assign w_rot = {i_key[23:0], i_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_in  (w_rot[31-8*b -: 8]),
      .o_out (w_sub[31-8*b -: 8])
    );
  end

  assign w_w0  = i_key[127:96] ^ w_sub ^ {i_rcon, 24'h000000};
  assign w_w1  = i_key[95:64] ^ w_w0;
  assign w_w2  = i_key[63:32] ^ w_w1;
  assign w_w3  = i_key[31:0] ^ w_w2;
  assign o_key = {w_w0, w_w1, w_w2, w_w3};

endmodule

// Forward AES S-box as a 256-entry table, entry 0 in the top byte.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = TABLE[{~i_in, 3'b000} +: 8];

endmodule

// Inverse AES S-box as a 256-entry table, entry 0 in the top byte.
module aes_inv_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign o_out = TABLE[{~i_in, 3'b000} +: 8];

endmodule
